// File: rtl/store_narrow_pkg.sv
// store_pkg: shared size codes, FSM state encodings and byte-enable helper for store_narrow
package store_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;
  function automatic logic [3:0] calc_be(input size_e size, input logic [1:0] lo);
    return size == SZ_BYTE ? 4'b0001 << lo :
           size == SZ_HALF ? (lo[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/store_narrow_if.sv
// store_narrow_if: store request and data-memory port bundle for store_narrow
//   request : req_valid/req_ready handshake, req_addr, req_data, req_size
//   status  : done, misalign (one-cycle pulses)
//   memory  : mem_addr, mem_wdata, mem_be, mem_we, mem_re, mem_rdata, mem_ack
//   slave modport is the store_narrow side, master is the requester/memory side
interface store_narrow_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
    output req_ready, done, misalign, mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
    input  req_ready, done, misalign, mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );
endinterface

// File: rtl/store_lane_merge.sv
// store_lane_merge: places store data on little-endian byte lanes, merges into an old word, flags misalignment
//   in : size, lo (addr[1:0]), data (right-justified), old (word read back from memory)
//   out: lane_data (unused lanes 0), be, merged (store lanes over old), misalign
module store_lane_merge
  import store_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lo,
  input  logic [31:0] data,
  input  logic [31:0] old,
  output logic [31:0] lane_data,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic        misalign
);
  logic [31:0] mask;
  logic [31:0] bm;
  assign be        = calc_be(size, lo);
  assign mask      = size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
  assign lane_data = size == SZ_WORD ? data : (data & mask) << {lo, 3'b000};
  assign bm        = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged    = (lane_data & bm) | (old & ~bm);
  assign misalign  = size == SZ_BAD || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
endmodule

// File: rtl/store_narrow.sv
// store_narrow: store lane formatter and data-memory write sequencer (direct write or read-modify-write)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : store_narrow_if.slave (request handshake, done/misalign pulses, memory port)
//   DMEM_BYTE_EN_EN defined: memory honours mem_be, byte/half stores write directly with partial be
//   DMEM_BYTE_EN_EN undefined: byte/half stores read the word, merge, then write it back with be=1111
module store_narrow
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            rst,
  store_narrow_if.slave  bus
);
`ifdef DMEM_BYTE_EN_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  size_e             size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              idle;
  size_e             m_size;
  logic [1:0]        m_lo;
  logic [31:0]       m_data;
  logic [31:0]       lane_data;
  logic [31:0]       merged;
  logic [3:0]        lane_be;
  logic              bad;
  assign idle = state_q == ST_IDLE;
  // In IDLE the merge unit classifies the incoming request; once busy it works on the captured store for the RMW merge.
  assign m_size = idle ? size_e'(bus.req_size) : size_q;
  assign m_lo   = idle ? bus.req_addr[1:0] : lo_q;
  assign m_data = idle ? bus.req_data : data_q;
  store_lane_merge u_merge (
    .size      (m_size),
    .lo        (m_lo),
    .data      (m_data),
    .old       (bus.mem_rdata),
    .lane_data (lane_data),
    .be        (lane_be),
    .merged    (merged),
    .misalign  (bad)
  );
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    be_d       = be_q;
    size_d     = size_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    if (idle && bus.req_valid) begin
      if (bad) begin
        misalign_d = 1'b1;
      end else begin
        state_d = (BYTE_EN || m_size == SZ_WORD) ? ST_WRITE : ST_READ;
        addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
        wdata_d = lane_data;
        be_d    = BYTE_EN ? lane_be : 4'hf;
        size_d  = m_size;
        lo_d    = m_lo;
        data_d  = m_data;
      end
    end
    if (state_q == ST_READ && bus.mem_ack) begin
      state_d = ST_WRITE;
      wdata_d = merged;
    end
    if (state_q == ST_WRITE && bus.mem_ack) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
      size_q     <= SZ_BYTE;
      lo_q       <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      be_q       <= be_d;
      size_q     <= size_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end
  assign bus.req_ready = idle && !rst;
  assign bus.done      = done_q;
  assign bus.misalign  = misalign_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_we    = state_q == ST_WRITE;
`ifdef DMEM_BYTE_EN_EN
  assign bus.mem_re    = 1'b0;
`else
  assign bus.mem_re    = state_q == ST_READ;
`endif
endmodule

// File: doc/store_narrow.md
# store_narrow

Store-path lane formatter and memory write sequencer for the data-memory port. It is the store-side counterpart of the load sign/zero extenders. It takes a 32-bit register value plus a byte, half or word size from the MEM stage and places the valid bytes on the correct memory lanes. It then runs the write to data memory under a valid/ack handshake, optionally as a read-modify-write, and flags misaligned stores instead of issuing them.

## Interface
- `ADDR_W`, default 32: byte-address width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE and while `rst` is low.
- `req_addr`  in  ADDR_W  byte address.
- `req_data`  in  32  store data, right-justified.
- `req_size`  in  2  size code: 00 byte, 01 half, 10 word, 11 illegal.
- `done`  out  1  one-cycle pulse when a store completes.
- `misalign`  out  1  one-cycle pulse when a request is rejected.
- `mem_addr`  out  ADDR_W  word-aligned address, low 2 bits forced to 0.
- `mem_wdata`  out  32  write data.
- `mem_be`  out  4  byte enables; bit k enables bits [8k+7:8k].
- `mem_we`  out  1  write request, held until ack.
- `mem_re`  out  1  read request, held until ack.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  memory completion for the current `mem_we`/`mem_re`.

## Operation
- **Lane mapping (little-endian).**
  - Byte: lane = addr[1:0], `be` = 1 << lane.
  - Half: lane pair = addr[1], `be` = 0011 or 1100.
  - Word: `be` = 1111.
  - Data is shifted into the selected lanes; unused lanes are 0.
- **Acceptance.** A request is accepted on a clock edge where `req_valid & req_ready`. Address, data and size are registered at that edge.
- **Misalignment.** A request is rejected if it is a half with addr[0]=1, a word with addr[1:0]≠0, or size 11. On rejection:
  - no memory access is made;
  - `misalign` pulses in the next cycle;
  - the FSM stays in IDLE;
  - `done` is not asserted.
- **FSM states:** IDLE, READ, WRITE.
  - IDLE → WRITE: accepted aligned word, or any aligned store in byte-enable mode.
  - IDLE → READ: accepted aligned byte/half in read-modify-write (RMW) mode.
  - READ: `mem_re`=1. On an edge with `mem_ack`, capture `mem_rdata`, merge the store lanes into it, then go to WRITE.
  - WRITE: `mem_we`=1. On an edge with `mem_ack`, go to IDLE and set `done` for one cycle.
- **Ack handling.** `mem_ack` is ignored when neither `mem_we` nor `mem_re` is asserted.
- **Stable outputs.** `mem_addr`, `mem_wdata` and `mem_be` stay stable for the whole time `mem_we` or `mem_re` is held.

## Timing
- **Reset values:** state IDLE, `done`=0, `misalign`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `req_ready`=0 while `rst` is high.
- **Outputs:** `mem_we`, `mem_re` and `req_ready` are decoded from the state register. No output depends combinationally on `req_*` or `mem_ack`.
- **Minimum latency, direct write:**
  - accept at edge T;
  - `mem_we` high in cycle T+1;
  - with ack in T+1, `done` and `req_ready` are high in T+2.
- **Minimum latency, RMW byte/half:** `done` is high in T+3.
- **Back-to-back:** a new request can be accepted in the same cycle `done` is high.
- **Reset mid-operation:** `rst` immediately drops `mem_we`/`mem_re` and returns to IDLE. The in-flight store is discarded with no `done`. A late `mem_ack` after reset is ignored.

## Configuration
- `DMEM_BYTE_EN_EN` defined: memory honours `mem_be`. Byte and half stores go straight to WRITE with partial `be`. READ is never entered and `mem_re` is tied 0.
- `DMEM_BYTE_EN_EN` undefined: memory ignores `be`. Byte and half stores use READ then WRITE with the merged word and `be`=1111. Word stores write directly with `be`=1111.

## Structure
- **Shared package `store_pkg`:**
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state encodings `ST_IDLE`, `ST_READ`, `ST_WRITE`;
  - a function computing byte enables from size and addr[1:0].
- **Sub-module `store_lane_merge`** (combinational):
  - inputs: size, addr[1:0], data, old word;
  - outputs: lane-shifted data, `be`, merged word, misalign flag.
  - The top level holds the FSM and the registers.

## Test plan
- Byte-enable mode, byte store addr 0x1003, data 0x000000AB, ack in the first cycle → `mem_addr` 0x1000, `be` 1000, `wdata` 0xAB000000, `done` 2 cycles after acceptance.
- Byte-enable mode, half store addr 0x2002, data 0x1234BEEF → `be` 1100, `wdata` 0xBEEF0000, `mem_re` never high.
- RMW mode, byte store addr 0x3001, data 0x55, read returns 0x11223344 → `mem_re` then `mem_we`, `wdata` 0x11225544, `be` 1111, `done` at T+3.
- Half store addr 0x0001, and separately size 11 → `misalign` one-cycle pulse, no `mem_we`/`mem_re`, `req_ready` high next cycle.
- `rst` asserted in WRITE with ack withheld → `mem_we` drops immediately, no `done`; the next word store at 0x40 completes normally.
- Two word stores back-to-back, ack delayed 3 cycles each → `req_ready` low while busy, two `done` pulses, writes in order.
